dead_time_monitor: RTL

- Receive-side checker for a complementary gate pair driven by the dead-time generator.
- Samples both gate lines, removes the per-leg output polarity and reconstructs the PWM command.
- Measures the actual dead time at each commutation and latches shoot-through and minimum-dead-time faults.
- `trip` feeds the upstream pwm_onoff gating; dt_meas_* feed the PS-readable register bank.

---
 rtl/dead_time_monitor_pkg.sv | 17 +
 rtl/dead_time_monitor_sync.sv | 24 ++
 rtl/dead_time_monitor.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dead_time_monitor_pkg.sv
// Shared types and constants for the gate-pair dead-time monitor.
// Holds the monitor FSM state encoding and default counter widths.
package dead_time_monitor_pkg;

   localparam int DTCOUNT_WIDTH = 8;
   localparam int OVL_W         = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A_ON  = 3'd1,
      B_ON  = 3'd2,
      GAP_A = 3'd3,
      GAP_B = 3'd4,
      OVL   = 3'd5
   } dtmon_state_e;

endpackage

// File: rtl/dead_time_monitor_sync.sv
// One-bit flop-chain synchronizer, async reset to 0.
// Ports: clk, reset, d (async level in), q (synchronized level out).
module dead_time_monitor_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift form keeps STAGES=1 legal (no [STAGES-2:0] slice).
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         chain <= '0;
      else
         chain <= (chain << 1) | STAGES'(d);
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/dead_time_monitor.sv
// Dead-time / shoot-through checker for a complementary gate pair.
// Ports: clk, reset, gate_A/B, logic_A/B, mon_en, dt_min, fault_clr in;
//        pwm_rec, dt_meas_A/B, meas_valid_A/B, fault_*, trip, state out.
module dead_time_monitor
   import dead_time_monitor_pkg::*;
#(
   parameter int DT_W        = DTCOUNT_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int OVL_FILTER  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            gate_A,
   input  logic            gate_B,
   input  logic            logic_A,
   input  logic            logic_B,
   input  logic            mon_en,
   input  logic [DT_W-1:0] dt_min,
   input  logic            fault_clr,
   output logic            pwm_rec,
   output logic [DT_W-1:0] dt_meas_A,
   output logic [DT_W-1:0] dt_meas_B,
   output logic            meas_valid_A,
   output logic            meas_valid_B,
   output logic            fault_overlap,
   output logic            fault_dtmin,
   output logic            trip,
   output logic [2:0]      state
);

   localparam logic [OVL_W-1:0] OVL_MAX = OVL_W'(OVL_FILTER);

   logic sync_a, sync_b;
   logic on_a, on_b;
   logic both, neither, only_a, only_b;

   dtmon_state_e     st, st_nxt;
   logic [DT_W-1:0]  gap_cnt, gap_nxt, gap_inc;
   logic [DT_W-1:0]  meas_val;
   logic [OVL_W-1:0] ovl_cnt, ovl_nxt;
   logic             ovl_hit;
   logic             take_a, take_b;
   logic             dt_fail;

   dead_time_monitor_sync #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk   (clk),
      .reset (reset),
      .d     (gate_A),
      .q     (sync_a)
   );

   dead_time_monitor_sync #(.STAGES(SYNC_STAGES)) u_sync_b (
      .clk   (clk),
      .reset (reset),
      .d     (gate_B),
      .q     (sync_b)
   );

   // Strip per-leg pin polarity: 1 = leg conducting.
   assign on_a = sync_a ^ ~logic_A;
   assign on_b = sync_b ^ ~logic_B;

   assign both    =  on_a &  on_b;
   assign neither = ~on_a & ~on_b;
   assign only_a  =  on_a & ~on_b;
   assign only_b  = ~on_a &  on_b;

   // Overlap run length saturates at the filter so a held overlap
   // keeps asserting ovl_hit (and so beats fault_clr).
   assign ovl_nxt = !both ? '0 :
                    (ovl_cnt == OVL_MAX) ? ovl_cnt : ovl_cnt + 1'b1;
   assign ovl_hit = mon_en && both && (ovl_nxt == OVL_MAX);

   assign gap_inc = (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;

   always_comb begin
      st_nxt   = st;
      gap_nxt  = gap_cnt;
      meas_val = gap_cnt;
      take_a   = 1'b0;
      take_b   = 1'b0;
      if (!mon_en) begin
         st_nxt  = IDLE;
         gap_nxt = '0;
      end else if (ovl_hit) begin
         st_nxt = OVL;
      end else begin
         unique case (st)
            IDLE: begin
               if (only_a)      st_nxt = A_ON;
               else if (only_b) st_nxt = B_ON;
            end
            A_ON: begin
               if (neither) begin
                  st_nxt  = GAP_A;
                  gap_nxt = DT_W'(1);
               end else if (only_b) begin
                  st_nxt   = B_ON;
                  take_b   = 1'b1;
                  meas_val = '0;
               end
            end
            B_ON: begin
               if (neither) begin
                  st_nxt  = GAP_B;
                  gap_nxt = DT_W'(1);
               end else if (only_a) begin
                  st_nxt   = A_ON;
                  take_a   = 1'b1;
                  meas_val = '0;
               end
            end
            GAP_A: begin
               if (neither) begin
                  gap_nxt = gap_inc;
               end else if (only_b) begin
                  st_nxt = B_ON;
                  take_b = 1'b1;
               end else if (only_a) begin
                  st_nxt = A_ON;
               end
            end
            GAP_B: begin
               if (neither) begin
                  gap_nxt = gap_inc;
               end else if (only_a) begin
                  st_nxt = A_ON;
                  take_a = 1'b1;
               end else if (only_b) begin
                  st_nxt = B_ON;
               end
            end
            OVL: begin
               if (neither) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
         endcase
      end
   end

   assign dt_fail = (take_a | take_b) && (meas_val < dt_min);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st            <= IDLE;
         gap_cnt       <= '0;
         ovl_cnt       <= '0;
         pwm_rec       <= 1'b0;
         dt_meas_A     <= '0;
         dt_meas_B     <= '0;
         meas_valid_A  <= 1'b0;
         meas_valid_B  <= 1'b0;
         fault_overlap <= 1'b0;
         fault_dtmin   <= 1'b0;
         trip          <= 1'b0;
      end else begin
         st           <= st_nxt;
         gap_cnt      <= gap_nxt;
         ovl_cnt      <= mon_en ? ovl_nxt : '0;
         meas_valid_A <= take_a;
         meas_valid_B <= take_b;
         if (take_a) dt_meas_A <= meas_val;
         if (take_b) dt_meas_B <= meas_val;
         if (st_nxt == A_ON)      pwm_rec <= 1'b1;
         else if (st_nxt == B_ON) pwm_rec <= 1'b0;
         fault_overlap <= ovl_hit | (fault_overlap & ~fault_clr);
         fault_dtmin   <= dt_fail | (fault_dtmin & ~fault_clr);
         trip          <= fault_overlap | fault_dtmin;
      end
   end

   assign state = st;

endmodule
